// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, constants and baud-divider helper used by
//               both the receive and transmit paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver frame states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  // Clocks per oversample tick, truncated toward zero
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / (baud * int'(UART_OVERSAMPLE));
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running oversample tick divider with synchronous clear.
//               o_tick is high for one clock when the counter reaches DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Count 0..DIV-1 and wrap; a clear restarts the phase at 0
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, 16x oversampling with 3-sample majority
//               vote, FIFO_DEPTH-entry receive FIFO on a valid/ready port,
//               one-cycle framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_100mhz,
  input  logic       sys_rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned c_div   = baud_div(CLK_FREQ_HZ, BAUD);
  localparam int unsigned c_smp_w = $clog2(OVERSAMPLE);
  localparam int unsigned c_idx_w = c_smp_w + 4;
  // FIFO_DEPTH must be a power of two and at least 2 so pointers wrap freely
  localparam int unsigned c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;

  localparam logic [c_smp_w-1:0] c_smp_a    = c_smp_w'(6);
  localparam logic [c_smp_w-1:0] c_smp_b    = c_smp_w'(7);
  localparam logic [c_smp_w-1:0] c_smp_vote = c_smp_w'(8);
  localparam logic [c_smp_w-1:0] c_smp_last = c_smp_w'(OVERSAMPLE - 1);
  localparam logic [3:0]         c_bit_last = 4'(UART_DATA_BITS);
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(FIFO_DEPTH);

  // Line synchroniser and receive FSM state
  logic                      r_sync1, r_sync2;
  rx_state_t                 r_state;
  logic [c_idx_w-1:0]        r_tick_idx;
  logic                      r_smp_a, r_smp_b;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_frame_err;

  // Receive FIFO
  logic [7:0]                r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]        r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]        r_count;
  logic                      r_overrun;

  logic                      w_rx_s;
  logic                      w_start;
  logic                      w_tick;
  logic [c_smp_w-1:0]        w_smp;
  logic [3:0]                w_bit;
  logic                      w_vote;
  logic                      w_vote_tick;
  logic                      w_last_tick;
  logic                      w_push, w_pop, w_full, w_wr;

  assign w_rx_s      = r_sync2;
  assign w_start     = (r_state == IDLE) && !w_rx_s;
  assign w_smp       = r_tick_idx[c_smp_w-1:0];
  assign w_bit       = r_tick_idx[c_smp_w +: 4];
  assign w_vote      = (r_smp_a & r_smp_b) | (r_smp_a & w_rx_s) | (r_smp_b & w_rx_s);
  assign w_vote_tick = w_tick && (w_smp == c_smp_vote);
  assign w_last_tick = w_tick && (w_smp == c_smp_last);

  assign w_push = (r_state == STOP) && w_vote_tick && w_vote;
  assign w_pop  = (r_count != '0) && rx_ready_i;
  assign w_full = (r_count == c_full);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign w_wr   = w_push && (!w_full || w_pop);

  uart_baud_tick #(
    .DIV (c_div)
  ) u_tick (
    .clk    (clk_100mhz),
    .rst    (sys_rst_i),
    .i_clr  (w_start),
    .o_tick (w_tick)
  );

  // Two-stage synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: tick indexing, vote samples, shift register, framing error
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst_i) begin
      r_state     <= IDLE;
      r_tick_idx  <= '0;
      r_smp_a     <= 1'b1;
      r_smp_b     <= 1'b1;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_tick && (r_state != IDLE)) r_tick_idx <= r_tick_idx + 1'b1;
      if (w_tick && (w_smp == c_smp_a)) r_smp_a <= w_rx_s;
      if (w_tick && (w_smp == c_smp_b)) r_smp_b <= w_rx_s;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_tick_idx <= '0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_vote_tick) begin
            if (w_vote) r_state <= IDLE;
          end else if (w_last_tick) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_vote_tick) r_shift <= {w_vote, r_shift[UART_DATA_BITS-1:1]};
          if (w_last_tick && (w_bit == c_bit_last)) r_state <= STOP;
        end
        STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed
          if (w_vote_tick) begin
            if (w_vote) begin
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Receive FIFO with wrapping pointers, occupancy count and overrun pulse
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is forced to zero while empty so stale entries never show
  assign rx_data_o   = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
  assign rx_valid_o  = (r_count != '0);
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != IDLE);

endmodule
`default_nettype wire
